// File: rtl/fb_pkg.sv
// Shared types and helpers for the coalescing PSRAM framebuffer writer.
package fb_pkg;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_REQ     = 2'd1,
    ST_BURST   = 2'd2
  } fb_state_e;

  // Upper bounds that size the generic mask helper; real widths are truncated by the caller.
  localparam int MAX_PPB    = 32;
  localparam int MAX_MASK_W = 128;

  // Byte mask for one beat: bytes of unwritten pixel slots are 1 (not written).
  function automatic logic [MAX_MASK_W-1:0] beat_byte_mask(
    input logic [MAX_PPB-1:0] slot_vld,
    input int                 ppb,
    input int                 pix_bytes
  );
    logic [MAX_MASK_W-1:0] m;
    logic [MAX_PPB-1:0]    sh;
    m = '1;
    for (int b = 0; b < MAX_MASK_W; b++) begin
      if (b < ppb * pix_bytes) begin
        sh   = slot_vld >> (b / pix_bytes);
        m[b] = ~sh[0];
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/framebuffer_burst_writer_if.sv
// Pixel stream and PSRAM burst bus of the framebuffer writer.
interface framebuffer_burst_writer_if #(
  parameter int PIXEL_W = 16,
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 21
);
  // Pixel: transfer when i_pix_valid && o_pix_ready on a rising edge; ready never looks at valid.
  // PSRAM: o_psram_req holds with beat 0 until a one-cycle i_psram_gnt, then beats follow back to back.
  logic                i_pix_valid;
  logic [PIXEL_W-1:0]  i_pix_data;
  logic                o_pix_ready;
  logic                o_psram_req;
  logic                i_psram_gnt;
  logic [ADDR_W-1:0]   o_psram_addr;
  logic [DATA_W-1:0]   o_psram_data;
  logic [DATA_W/8-1:0] o_psram_data_mask;

  modport master (
    output i_pix_valid, i_pix_data, i_psram_gnt,
    input  o_pix_ready, o_psram_req, o_psram_addr, o_psram_data, o_psram_data_mask
  );

  modport slave (
    input  i_pix_valid, i_pix_data, i_psram_gnt,
    output o_pix_ready, o_psram_req, o_psram_addr, o_psram_data, o_psram_data_mask
  );
endinterface

// File: rtl/framebuffer_burst_writer_cursor.sv
// Window latch and raster cursor; gives the linear address of the pixel accepted this cycle.
module fb_window_cursor #(
  parameter int COORD_W     = 11,
  parameter int ADDR_W      = 21,
  parameter int LINE_STRIDE = 1280
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_win_set,
  input  logic [COORD_W-1:0] i_sx,
  input  logic [COORD_W-1:0] i_ex,
  input  logic [COORD_W-1:0] i_sy,
  input  logic [COORD_W-1:0] i_ey,
  input  logic               i_advance,
  output logic [ADDR_W-1:0]  o_addr
);
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(LINE_STRIDE);

  logic [COORD_W-1:0] sx_q, ex_q, sy_q, ey_q, col_q, row_q;
  logic [COORD_W-1:0] sx_d, ex_d, sy_d, ey_d, col_d, row_d;
  logic [COORD_W-1:0] cur_col, cur_row;

  // A window set takes effect in the same cycle so a coinciding pixel lands at (sx,sy).
  always_comb begin
    sx_d    = i_win_set ? i_sx : sx_q;
    ex_d    = i_win_set ? i_ex : ex_q;
    sy_d    = i_win_set ? i_sy : sy_q;
    ey_d    = i_win_set ? i_ey : ey_q;
    cur_col = i_win_set ? i_sx : col_q;
    cur_row = i_win_set ? i_sy : row_q;
    col_d   = cur_col;
    row_d   = cur_row;
    if (i_advance) begin
      if (cur_col >= ex_d) begin
        col_d = sx_d;
        row_d = (cur_row >= ey_d) ? sy_d : cur_row + COORD_W'(1);
      end else begin
        col_d = cur_col + COORD_W'(1);
      end
    end
  end

  assign o_addr = ADDR_W'(cur_row) * STRIDE + ADDR_W'(cur_col);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sx_q  <= '0;
      ex_q  <= '0;
      sy_q  <= '0;
      ey_q  <= '0;
      col_q <= '0;
      row_q <= '0;
    end else begin
      sx_q  <= sx_d;
      ex_q  <= ex_d;
      sy_q  <= sy_d;
      ey_q  <= ey_d;
      col_q <= col_d;
      row_q <= row_d;
    end
  end
endmodule

// File: rtl/framebuffer_burst_writer.sv
// Coalesces windowed pixels into masked PSRAM bursts, one aligned block at a time.
module framebuffer_burst_writer
  import fb_pkg::*;
#(
  parameter int PIXEL_W       = 16,
  parameter int DATA_W        = 64,
  parameter int BURST_BEATS   = 8,
  parameter int ADDR_W        = 21,
  parameter int COORD_W       = 11,
  parameter int LINE_STRIDE   = 1280,
  parameter int FLUSH_TIMEOUT = 64
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_win_set,
  input  logic [COORD_W-1:0]          i_sx,
  input  logic [COORD_W-1:0]          i_ex,
  input  logic [COORD_W-1:0]          i_sy,
  input  logic [COORD_W-1:0]          i_ey,
  input  logic                        i_flush,
  output logic                        o_busy,
  framebuffer_burst_writer_if.slave   bus
);
  localparam int PPB       = DATA_W / PIXEL_W;
  localparam int PPK       = PPB * BURST_BEATS;
  localparam int MASK_W    = DATA_W / 8;
  localparam int PIX_BYTES = PIXEL_W / 8;
  localparam int SLOT_W    = $clog2(PPK);
  localparam int BLK_W     = ADDR_W - SLOT_W;
  localparam int BEAT_W    = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
  localparam int IDLE_W    = $clog2(FLUSH_TIMEOUT + 2);

  fb_state_e                state_q, state_d;
  logic                     s1_vld_q, s1_vld_d;
  logic [ADDR_W-1:0]        s1_addr_q, s1_addr_d;
  logic [PIXEL_W-1:0]       s1_data_q, s1_data_d;
  logic [PPK-1:0]           buf_vld_q, buf_vld_d;
  logic [PPK*PIXEL_W-1:0]   buf_data_q, buf_data_d;
  logic [BLK_W-1:0]         buf_blk_q, buf_blk_d;
  logic [BEAT_W-1:0]        beat_q, beat_d;
  logic [IDLE_W-1:0]        idle_q, idle_d;

  logic [ADDR_W-1:0]        pix_addr;
  logic [BLK_W-1:0]         s1_blk;
  logic [SLOT_W-1:0]        s1_slot;
  logic                     buf_any, conflict, pix_ready, pix_accept, merge, active;
  logic [BEAT_W-1:0]        beat_idx;

  fb_window_cursor #(
    .COORD_W    (COORD_W),
    .ADDR_W     (ADDR_W),
    .LINE_STRIDE(LINE_STRIDE)
  ) u_cursor (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_win_set(i_win_set),
    .i_sx     (i_sx),
    .i_ex     (i_ex),
    .i_sy     (i_sy),
    .i_ey     (i_ey),
    .i_advance(pix_accept),
    .o_addr   (pix_addr)
  );

  assign s1_blk     = s1_addr_q[ADDR_W-1:SLOT_W];
  assign s1_slot    = s1_addr_q[SLOT_W-1:0];
  assign buf_any    = |buf_vld_q;
  assign conflict   = buf_any && (s1_blk != buf_blk_q);
  assign pix_ready  = (state_q == ST_COLLECT) && !(s1_vld_q && conflict);
  assign pix_accept = bus.i_pix_valid && pix_ready;

  always_comb begin
    state_d    = state_q;
    s1_vld_d   = s1_vld_q;
    s1_addr_d  = s1_addr_q;
    s1_data_d  = s1_data_q;
    buf_vld_d  = buf_vld_q;
    buf_data_d = buf_data_q;
    buf_blk_d  = buf_blk_q;
    beat_d     = beat_q;
    idle_d     = idle_q;
    merge      = 1'b0;
    case (state_q)
      ST_COLLECT: begin
        if (s1_vld_q && !conflict) begin
          merge                                       = 1'b1;
          buf_vld_d[s1_slot]                          = 1'b1;
          buf_data_d[s1_slot*PIXEL_W +: PIXEL_W]      = s1_data_q;
          buf_blk_d                                   = s1_blk;
          s1_vld_d                                    = 1'b0;
          idle_d                                      = '0;
        end else if (buf_any) begin
          idle_d = idle_q + IDLE_W'(1);
        end else begin
          idle_d = '0;
        end
        if (s1_vld_q && conflict) begin
          state_d = ST_REQ;
        end else if (i_flush && (buf_any || merge)) begin
          state_d = ST_REQ;
        end else if (&buf_vld_d) begin
          state_d = ST_REQ;
        end else if (FLUSH_TIMEOUT != 0 && !merge && buf_any &&
                     idle_d == IDLE_W'(FLUSH_TIMEOUT)) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.i_psram_gnt) begin
          state_d = ST_BURST;
          beat_d  = BEAT_W'(1);
        end
      end
      ST_BURST: begin
        if (beat_q == BEAT_W'(BURST_BEATS - 1)) begin
          state_d   = ST_COLLECT;
          buf_vld_d = '0;
          beat_d    = '0;
          idle_d    = '0;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      default: state_d = ST_COLLECT;
    endcase
    // Ready is only high when S1 is empty or merging, so a new pixel can always take S1.
    if (pix_accept) begin
      s1_vld_d  = 1'b1;
      s1_addr_d = pix_addr;
      s1_data_d = bus.i_pix_data;
    end
  end

  assign active                = (state_q != ST_COLLECT);
  assign beat_idx              = (state_q == ST_BURST) ? beat_q : '0;
  assign bus.o_pix_ready       = pix_ready;
  assign bus.o_psram_req       = (state_q == ST_REQ);
  assign bus.o_psram_addr      = active ? {buf_blk_q, SLOT_W'(0)} : '0;
  assign bus.o_psram_data      = active ? buf_data_q[beat_idx*DATA_W +: DATA_W] : '0;
  assign bus.o_psram_data_mask = active ?
      MASK_W'(beat_byte_mask(MAX_PPB'(buf_vld_q[beat_idx*PPB +: PPB]), PPB, PIX_BYTES)) : '1;
  assign o_busy                = buf_any || s1_vld_q || active;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_COLLECT;
      s1_vld_q   <= 1'b0;
      s1_addr_q  <= '0;
      s1_data_q  <= '0;
      buf_vld_q  <= '0;
      buf_data_q <= '0;
      buf_blk_q  <= '0;
      beat_q     <= '0;
      idle_q     <= '0;
    end else begin
      state_q    <= state_d;
      s1_vld_q   <= s1_vld_d;
      s1_addr_q  <= s1_addr_d;
      s1_data_q  <= s1_data_d;
      buf_vld_q  <= buf_vld_d;
      buf_data_q <= buf_data_d;
      buf_blk_q  <= buf_blk_d;
      beat_q     <= beat_d;
      idle_q     <= idle_d;
    end
  end
endmodule

// File: tb/tb_framebuffer_burst_writer.sv
// Directed bench for framebuffer_burst_writer with an expected-beat scoreboard.
module tb_framebuffer_burst_writer;
  localparam int EXP_W = 21 + 64 + 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        win_set, flush, busy;
  logic [10:0] sx, ex, sy, ey;
  logic        z_win_set, z_flush, z_busy;
  logic [10:0] z_coord;

  int checks = 0;
  int errors = 0;

  logic [EXP_W-1:0] exp_q[$];
  logic [15:0]      blk_pix[32];
  logic             blk_vld[32];
  logic [15:0]      stream[40];

  framebuffer_burst_writer_if bus ();
  framebuffer_burst_writer_if bus0 ();

  framebuffer_burst_writer #(.FLUSH_TIMEOUT(64)) dut (
    .i_clk(clk), .i_rst(rst), .i_win_set(win_set),
    .i_sx(sx), .i_ex(ex), .i_sy(sy), .i_ey(ey),
    .i_flush(flush), .o_busy(busy), .bus(bus)
  );

  framebuffer_burst_writer #(.FLUSH_TIMEOUT(0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_win_set(z_win_set),
    .i_sx(z_coord), .i_ex(z_coord), .i_sy(z_coord), .i_ey(z_coord),
    .i_flush(z_flush), .o_busy(z_busy), .bus(bus0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_window(input int a, input int b, input int c, input int d);
    sx = 11'(a); ex = 11'(b); sy = 11'(c); ey = 11'(d);
    win_set = 1'b1;
    step();
    win_set = 1'b0;
  endtask

  task automatic send_pix(input logic [15:0] d, input logic ws);
    int guard = 0;
    bus.i_pix_valid = 1'b1;
    bus.i_pix_data  = d;
    win_set         = ws;
    while (!bus.o_pix_ready && guard < 400) begin
      step();
      guard++;
    end
    chk("pix_ready_wait", bus.o_pix_ready, 1'b1);
    step();
    bus.i_pix_valid = 1'b0;
    win_set         = 1'b0;
  endtask

  task automatic flush_when_ready();
    int guard = 0;
    while (!bus.o_pix_ready && guard < 400) begin
      step();
      guard++;
    end
    chk("flush_wait", bus.o_pix_ready, 1'b1);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  // Turns the bench's slot picture of one block into eight expected beats.
  task automatic push_block(input logic [20:0] base);
    logic [63:0] d;
    logic [7:0]  m;
    for (int b = 0; b < 8; b++) begin
      d = '0;
      m = '0;
      for (int p = 0; p < 4; p++) begin
        if (blk_vld[b*4+p]) d[p*16 +: 16] = blk_pix[b*4+p];
        else                m[p*2 +: 2]   = 2'b11;
      end
      exp_q.push_back({base, d, m});
    end
    for (int j = 0; j < 32; j++) begin
      blk_vld[j] = 1'b0;
      blk_pix[j] = '0;
    end
  endtask

  task automatic check_beat(input int k);
    logic [EXP_W-1:0] e;
    logic [63:0]      keep;
    chk($sformatf("beat%0d_avail", k), exp_q.size() != 0, 1'b1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    for (int b = 0; b < 8; b++) keep[b*8 +: 8] = e[b] ? 8'h00 : 8'hFF;
    chk($sformatf("beat%0d_addr", k), bus.o_psram_addr, e[92:72]);
    chk($sformatf("beat%0d_mask", k), bus.o_psram_data_mask, e[7:0]);
    chk($sformatf("beat%0d_data", k), bus.o_psram_data & keep, e[71:8] & keep);
  endtask

  task automatic serve_burst(input int delay);
    int          guard = 0;
    logic [20:0] a0;
    logic [63:0] d0;
    logic [7:0]  m0;
    while (!bus.o_psram_req && guard < 400) begin
      step();
      guard++;
    end
    chk("req_seen", bus.o_psram_req, 1'b1);
    if (!bus.o_psram_req) return;
    a0 = bus.o_psram_addr;
    d0 = bus.o_psram_data;
    m0 = bus.o_psram_data_mask;
    for (int i = 0; i < delay; i++) begin
      step();
      chk("hold_req", bus.o_psram_req, 1'b1);
      chk("hold_addr", bus.o_psram_addr, a0);
      chk("hold_data", bus.o_psram_data, d0);
      chk("hold_mask", bus.o_psram_data_mask, m0);
      chk("hold_ready_low", bus.o_pix_ready, 1'b0);
    end
    check_beat(0);
    bus.i_psram_gnt = 1'b1;
    step();
    bus.i_psram_gnt = 1'b0;
    chk("req_drop", bus.o_psram_req, 1'b0);
    for (int k = 1; k < 8; k++) begin
      if (k > 1) step();
      check_beat(k);
    end
  endtask

  initial begin
    int  n;
    logic saw;
    rst = 1'b1;
    win_set = 1'b0; flush = 1'b0;
    sx = '0; ex = '0; sy = '0; ey = '0;
    z_win_set = 1'b0; z_flush = 1'b0; z_coord = '0;
    bus.i_pix_valid = 1'b0; bus.i_pix_data = '0; bus.i_psram_gnt = 1'b0;
    bus0.i_pix_valid = 1'b0; bus0.i_pix_data = '0; bus0.i_psram_gnt = 1'b0;
    for (int j = 0; j < 32; j++) begin
      blk_vld[j] = 1'b0;
      blk_pix[j] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", bus.o_psram_req, 1'b0);
    chk("rst_mask", bus.o_psram_data_mask, 8'hFF);
    chk("rst_data", bus.o_psram_data, 64'h0);
    chk("rst_addr", bus.o_psram_addr, 21'h0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    step();
    chk("idle_ready", bus.o_pix_ready, 1'b1);

    // Full block of 32 sequential pixels.
    set_window(0, 1279, 0, 719);
    for (int i = 0; i < 32; i++) begin
      blk_pix[i] = 16'h1000 + 16'(i);
      blk_vld[i] = 1'b1;
    end
    push_block(21'd0);
    for (int i = 0; i < 32; i++) send_pix(16'h1000 + 16'(i), 1'b0);
    chk("full_busy", busy, 1'b1);
    serve_burst(0);
    step();
    chk("full_done_busy", busy, 1'b0);

    // Narrow window straddling block boundaries.
    set_window(30, 33, 0, 1);
    blk_pix[30] = 16'h2000; blk_pix[31] = 16'h2001; blk_vld[30] = 1; blk_vld[31] = 1;
    push_block(21'd0);
    blk_pix[0] = 16'h2002; blk_pix[1] = 16'h2003; blk_vld[0] = 1; blk_vld[1] = 1;
    push_block(21'd32);
    blk_pix[30] = 16'h2004; blk_pix[31] = 16'h2005; blk_vld[30] = 1; blk_vld[31] = 1;
    push_block(21'd1280);
    blk_pix[0] = 16'h2006; blk_pix[1] = 16'h2007; blk_vld[0] = 1; blk_vld[1] = 1;
    push_block(21'd1312);
    fork
      begin
        for (int i = 0; i < 8; i++) send_pix(16'h2000 + 16'(i), 1'b0);
        flush_when_ready();
      end
      begin
        for (int b = 0; b < 4; b++) serve_burst(0);
      end
    join
    step();
    chk("window_done_busy", busy, 1'b0);

    // Single pixel placed by a coinciding window set, then auto-flush by timeout.
    sx = 11'd5; ex = 11'd1279; sy = 11'd2; ey = 11'd719;
    blk_pix[5] = 16'h3A3A; blk_vld[5] = 1'b1;
    push_block(21'd2560);
    send_pix(16'h3A3A, 1'b1);
    chk("timeout_busy", busy, 1'b1);
    n = 0;
    while (!bus.o_psram_req && n < 200) begin
      step();
      n++;
    end
    chk("timeout_cycles", n, 65);
    serve_burst(0);
    step();

    // Continuous stream while the grant is held off for 10 cycles.
    set_window(0, 1279, 0, 719);
    for (int i = 0; i < 40; i++) stream[i] = 16'($urandom_range(0, 65535));
    for (int i = 0; i < 32; i++) begin
      blk_pix[i] = stream[i];
      blk_vld[i] = 1'b1;
    end
    push_block(21'd0);
    for (int i = 0; i < 8; i++) begin
      blk_pix[i] = stream[32+i];
      blk_vld[i] = 1'b1;
    end
    push_block(21'd32);
    fork
      begin
        for (int i = 0; i < 40; i++) send_pix(stream[i], 1'b0);
        flush_when_ready();
      end
      begin
        serve_burst(10);
        serve_burst(0);
      end
    join
    step();

    // Repeated slot: last write wins.
    sx = 11'd7; ex = 11'd7; sy = 11'd3; ey = 11'd3;
    blk_pix[7] = 16'h5555; blk_vld[7] = 1'b1;
    push_block(21'd3840);
    send_pix(16'hAAAA, 1'b1);
    send_pix(16'h5555, 1'b0);
    flush_when_ready();
    serve_burst(0);
    step();

    // Flush with an empty buffer does nothing.
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    chk("empty_flush_req", bus.o_psram_req, 1'b0);

    // Timeout disabled: only an explicit flush starts the burst.
    bus0.i_pix_valid = 1'b1;
    bus0.i_pix_data  = 16'h7777;
    chk("z_ready", bus0.o_pix_ready, 1'b1);
    step();
    bus0.i_pix_valid = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      saw |= bus0.o_psram_req;
    end
    chk("z_no_timeout", saw, 1'b0);
    z_flush = 1'b1;
    step();
    z_flush = 1'b0;
    chk("z_flush_req", bus0.o_psram_req, 1'b1);
    chk("z_addr", bus0.o_psram_addr, 21'h0);
    chk("z_mask", bus0.o_psram_data_mask, 8'hFC);
    chk("z_data", bus0.o_psram_data[15:0], 16'h7777);
    bus0.i_psram_gnt = 1'b1;
    step();
    bus0.i_psram_gnt = 1'b0;
    repeat (8) step();
    chk("z_done_busy", z_busy, 1'b0);

    // Reset in the middle of a burst.
    set_window(0, 1279, 0, 719);
    send_pix(16'hBEEF, 1'b0);
    flush_when_ready();
    n = 0;
    while (!bus.o_psram_req && n < 50) begin
      step();
      n++;
    end
    chk("rst_burst_req", bus.o_psram_req, 1'b1);
    bus.i_psram_gnt = 1'b1;
    step();
    bus.i_psram_gnt = 1'b0;
    step();
    step();
    chk("beat3_mask", bus.o_psram_data_mask, 8'hFF);
    rst = 1'b1;
    #1;
    chk("midrst_req", bus.o_psram_req, 1'b0);
    chk("midrst_mask", bus.o_psram_data_mask, 8'hFF);
    chk("midrst_busy", busy, 1'b0);
    step();
    step();
    rst = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      saw |= bus.o_psram_req;
    end
    chk("no_beats_after_rst", saw, 1'b0);
    chk("post_rst_busy", busy, 1'b0);
    blk_pix[0] = 16'h1234; blk_vld[0] = 1'b1;
    push_block(21'd0);
    send_pix(16'h1234, 1'b0);
    flush_when_ready();
    serve_burst(0);
    step();

    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
